// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, data-RAM FSM states and lane-strobe helpers.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } ram_state_e;

  // Byte-lane enables for a little-endian 32-bit bus.
  function automatic logic [3:0] lane_strobe(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      HSIZE_BYTE: strb = 4'b0001 << addr_lo;
      HSIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: strb = 4'b1111;
      default:    strb = 4'b0000;
    endcase
    return strb;
  endfunction

  // Flags sizes this bus cannot carry as well as addresses not aligned to the size.
  function automatic logic lane_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      HSIZE_BYTE: bad = 1'b0;
      HSIZE_HALF: bad = addr_lo[0];
      HSIZE_WORD: bad = (addr_lo != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ahb_lane_decode.sv
// Combinational HSIZE/address lane decoder, reusable by any 32-bit AHB slave.
module ahb_lane_decode
  import ahb_pkg::*;
(
  input  logic [2:0] size_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] strobe_o,
  output logic       misalign_o
);

  // Lane enables and alignment check for one transfer.
  always_comb begin
    strobe_o   = lane_strobe(size_i, addr_lo_i);
    misalign_o = lane_misaligned(size_i, addr_lo_i);
  end

endmodule

// File: rtl/ahb_data_ram.sv
// AHB-Lite data RAM slave: pipelined address/data phases, byte lanes,
// programmable wait states and a two-cycle ERROR response.
module ahb_data_ram
  import ahb_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        sync_reset_n,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned Words = DEPTH_BYTES / 4;
  localparam int unsigned IdxW  = (Words > 1) ? $clog2(Words) : 1;

  ram_state_e      state_q;
  logic [2:0]      wait_cnt_q;
  logic [IdxW-1:0] idx_q;
  logic [1:0]      addr_lo_q;
  logic [2:0]      size_q;
  logic            write_q;
  logic            hreadyout_q;
  logic            hresp_q;

  logic            accept;
  logic            addr_err;
  logic [3:0]      strobe;
  logic            dp_misalign;

  logic [31:0]     mem [Words];

  // Address-phase qualification and error classification.
  always_comb begin
    accept   = HSEL && HREADY && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
    addr_err = lane_misaligned(HSIZE, HADDR[1:0]) || (HADDR >= DEPTH_BYTES);
  end

  // Lane enables for the transfer currently in its data phase.
  ahb_lane_decode u_lane_decode (
    .size_i     (size_q),
    .addr_lo_i  (addr_lo_q),
    .strobe_o   (strobe),
    .misalign_o (dp_misalign)
  );

  // Control FSM: captures the address phase, counts wait states, registers the response.
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      idx_q       <= '0;
      addr_lo_q   <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      case (state_q)
        StWait: begin
          if (wait_cnt_q == '0) begin
            state_q     <= StData;
            hreadyout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
          end
        end
        StErr1: begin
          state_q     <= StErr2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        // Idle, Data and Err2 all present HREADYOUT high, so a new transfer may start here.
        default: begin
          if (accept) begin
            idx_q     <= IdxW'(HADDR[31:2]);
            addr_lo_q <= HADDR[1:0];
            size_q    <= HSIZE;
            write_q   <= HWRITE;
            if (addr_err) begin
              state_q     <= StErr1;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_ERROR;
            end else if (WAIT_STATES == 0) begin
              state_q     <= StData;
              hreadyout_q <= 1'b1;
              hresp_q     <= HRESP_OKAY;
            end else begin
              state_q     <= StWait;
              wait_cnt_q  <= 3'(WAIT_STATES - 1);
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_OKAY;
            end
          end else begin
            state_q     <= StIdle;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  // Byte-enabled write at the end of an OKAY write data phase; reset drops it.
  always_ff @(posedge clk) begin
    if (sync_reset_n && (state_q == StData) && write_q && !dp_misalign) begin
      for (int i = 0; i < 4; i++) begin
        if (strobe[i]) begin
          mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  // Read data is combinational from the array so a write committed at this edge is visible.
  always_comb begin
    HRDATA = '0;
    if ((state_q == StData) && !write_q) begin
      HRDATA = mem[idx_q];
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_data_ram.sv
// Bench for ahb_data_ram: two instances (0 and 2 wait states) run the same transfer
// list; a byte-level memory model predicts every cycle of the bus response.
module tb_ahb_data_ram;
  import ahb_pkg::*;

  localparam int unsigned Depth = 1024;
  localparam int KIdle   = 0;
  localparam int KBusy   = 1;
  localparam int KNonseq = 2;
  localparam int KSeq    = 3;
  localparam int KUnsel  = 4;
  localparam int KReset  = 5;
  localparam int MaxCyc  = 20000;

  typedef struct {
    int        kind;
    bit        write;
    bit [2:0]  size;
    bit [31:0] addr;
    bit [31:0] wdata;
  } op_t;

  // Expected bus response for one cycle, plus the transfer it belongs to.
  typedef struct {
    bit        chk;
    bit        ready;
    bit        resp;
    bit        rd;
    bit        wr;
    bit [31:0] addr;
    bit [2:0]  size;
    bit [31:0] wdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n  [2];
  logic        hsel   [2];
  logic [31:0] haddr  [2];
  logic [1:0]  htrans [2];
  logic        hwrite [2];
  logic [2:0]  hsize  [2];
  logic [31:0] hwdata [2];
  logic        hro0, hro1, hrs0, hrs1;
  logic [31:0] hrd0, hrd1;

  int          checks = 0;
  int          errors = 0;
  op_t         ops[$];
  exp_t        cur_e [2];
  logic [31:0] obs_rd [2];
  bit   [7:0]  mbyte [2][Depth];
  bit          known [2][Depth];

  always #5 clk = ~clk;

  ahb_data_ram #(.DEPTH_BYTES(Depth), .WAIT_STATES(0)) dut0 (
    .clk(clk), .sync_reset_n(rst_n[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
    .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]),
    .HREADY(hro0), .HREADYOUT(hro0), .HRESP(hrs0), .HRDATA(hrd0)
  );

  ahb_data_ram #(.DEPTH_BYTES(Depth), .WAIT_STATES(2)) dut2 (
    .clk(clk), .sync_reset_n(rst_n[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
    .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]),
    .HREADY(hro1), .HREADYOUT(hro1), .HRESP(hrs1), .HRDATA(hrd1)
  );

  task automatic check(input int d, input string name, input logic [31:0] act,
                       input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %h expected %h", name, d, $time, act, want);
    end
  endtask

  function automatic op_t mk_op(input int kind, input bit write, input bit [2:0] size,
                                input bit [31:0] addr, input bit [31:0] wdata);
    op_t o;
    o.kind = kind; o.write = write; o.size = size; o.addr = addr; o.wdata = wdata;
    return o;
  endfunction

  function automatic exp_t mk_exp(input bit ready, input bit resp, input bit rd, input bit wr,
                                  input op_t o);
    exp_t e;
    e.chk = 1'b1; e.ready = ready; e.resp = resp; e.rd = rd; e.wr = wr;
    e.addr = o.addr; e.size = o.size; e.wdata = o.wdata;
    return e;
  endfunction

  function automatic exp_t idle_exp();
    return mk_exp(1'b1, 1'b0, 1'b0, 1'b0, mk_op(KIdle, 1'b0, 3'd0, 32'd0, 32'd0));
  endfunction

  // A transfer errors if its size is unsupported, it is not size-aligned, or it is past the end.
  function automatic bit is_err(input op_t o);
    if (o.size > 3'd2) return 1'b1;
    if ((o.addr % (32'd1 << o.size)) != 0) return 1'b1;
    return o.addr >= Depth;
  endfunction

  // Writes (1 << size) consecutive bytes; byte at address a travels on lane a % 4.
  task automatic commit(input int d, input exp_t e);
    int a;
    for (int b = 0; b < (1 << e.size); b++) begin
      a = int'(e.addr) + b;
      mbyte[d][a] = e.wdata[8*(a % 4) +: 8];
      known[d][a] = 1'b1;
    end
  endtask

  function automatic logic [31:0] model_word(input int d, input int addr);
    logic [31:0] w;
    int base;
    base = addr - (addr % 4);
    for (int l = 0; l < 4; l++) w[8*l +: 8] = mbyte[d][base + l];
    return w;
  endfunction

  task automatic drive(input int d, input op_t o, input exp_t cur);
    rst_n[d]  = (o.kind != KReset);
    hsel[d]   = (o.kind <= KSeq);
    case (o.kind)
      KIdle:   htrans[d] = HTRANS_IDLE;
      KBusy:   htrans[d] = HTRANS_BUSY;
      KNonseq: htrans[d] = HTRANS_NONSEQ;
      KSeq:    htrans[d] = HTRANS_SEQ;
      KUnsel:  htrans[d] = HTRANS_NONSEQ;
      default: htrans[d] = HTRANS_IDLE;
    endcase
    haddr[d]  = o.addr;
    hwrite[d] = o.write;
    hsize[d]  = o.size;
    hwdata[d] = cur.wr ? cur.wdata : $urandom();
  endtask

  // Master + model for one DUT: steps the op list one cycle at a time.
  task automatic run(input int d);
    exp_t q[$];
    exp_t cur;
    op_t  o;
    int   i;
    int   cyc;
    int   ws;
    i = 0; cyc = 0; ws = (d == 0) ? 0 : 2;
    cur = cur_e[d];
    while ((i < ops.size() || q.size() != 0) && cyc < MaxCyc) begin
      o = (i < ops.size()) ? ops[i] : mk_op(KIdle, 1'b0, 3'd0, 32'd0, 32'd0);
      drive(d, o, cur);
      @(posedge clk); #1;
      cyc++;
      if (o.kind == KReset) begin
        q.delete();
        i++;
      end else begin
        if (cur.ready && cur.wr) commit(d, cur);
        if (q.size() != 0) void'(q.pop_front());
        if (cur.ready && i < ops.size()) begin
          if (o.kind == KNonseq || o.kind == KSeq) begin
            if (is_err(o)) begin
              q.push_back(mk_exp(1'b0, 1'b1, 1'b0, 1'b0, o));
              q.push_back(mk_exp(1'b1, 1'b1, 1'b0, 1'b0, o));
            end else begin
              for (int w = 0; w < ws; w++) q.push_back(mk_exp(1'b0, 1'b0, 1'b0, 1'b0, o));
              q.push_back(mk_exp(1'b1, 1'b0, !o.write, o.write, o));
            end
          end
          i++;
        end
      end
      cur = (q.size() != 0) ? q[0] : idle_exp();
      cur_e[d] = cur;
    end
    if (cyc >= MaxCyc) begin
      checks++;
      errors++;
      $display("FAIL run_budget dut%0d t=%0t got %0d cycles expected under %0d", d, $time, cyc,
               MaxCyc);
    end
    drive(d, mk_op(KIdle, 1'b0, 3'd0, 32'd0, 32'd0), cur);
  endtask

  task automatic run_both();
    fork
      run(0);
      run(1);
    join
  endtask

  task automatic pin(input string name, input int addr, input logic [31:0] want);
    for (int d = 0; d < 2; d++) begin
      check(d, {name, "_read"}, obs_rd[d], want);
      check(d, {name, "_model"}, model_word(d, addr), want);
    end
  endtask

  // Compare every DUT output against the model on the falling edge.
  always @(negedge clk) begin
    exp_t        e;
    logic        ro, rs;
    logic [31:0] rd, er, mk;
    int          base;
    for (int d = 0; d < 2; d++) begin
      e = cur_e[d];
      if (e.chk) begin
        ro = (d == 0) ? hro0 : hro1;
        rs = (d == 0) ? hrs0 : hrs1;
        rd = (d == 0) ? hrd0 : hrd1;
        check(d, "hreadyout", {31'd0, ro}, {31'd0, e.ready});
        check(d, "hresp", {31'd0, rs}, {31'd0, e.resp});
        er = '0;
        mk = '1;
        if (e.rd && e.ready && !e.resp) begin
          base = int'(e.addr) - (int'(e.addr) % 4);
          for (int l = 0; l < 4; l++) begin
            er[8*l +: 8] = mbyte[d][base + l];
            mk[8*l +: 8] = known[d][base + l] ? 8'hff : 8'h00;
          end
          obs_rd[d] = rd;
        end
        check(d, "hrdata", rd & mk, er & mk);
      end
    end
  end

  initial begin
    op_t      o;
    int       r;
    bit [2:0] sz;
    bit [31:0] a;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; hsel[d] = 1'b0; haddr[d] = '0; htrans[d] = HTRANS_IDLE;
      hwrite[d] = 1'b0; hsize[d] = HSIZE_BYTE; hwdata[d] = '0; obs_rd[d] = '0;
      cur_e[d] = idle_exp();
      cur_e[d].chk = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset, then word write and read-back.
    ops.delete();
    ops.push_back(mk_op(KReset, 1'b0, HSIZE_BYTE, 32'h0, 32'h0));
    ops.push_back(mk_op(KNonseq, 1'b1, HSIZE_WORD, 32'h010, 32'hDEADBEEF));
    ops.push_back(mk_op(KNonseq, 1'b0, HSIZE_WORD, 32'h010, 32'h0));
    run_both();
    pin("word_rw", 32'h010, 32'hDEADBEEF);

    // Byte lane 3 with garbage on the other lanes.
    ops.delete();
    ops.push_back(mk_op(KNonseq, 1'b1, HSIZE_BYTE, 32'h013, 32'hAA112233));
    ops.push_back(mk_op(KSeq, 1'b0, HSIZE_WORD, 32'h010, 32'h0));
    run_both();
    pin("byte_rw", 32'h010, 32'hAAADBEEF);

    // Lower halfword.
    ops.delete();
    ops.push_back(mk_op(KNonseq, 1'b1, HSIZE_HALF, 32'h010, 32'h99881234));
    ops.push_back(mk_op(KNonseq, 1'b0, HSIZE_WORD, 32'h010, 32'h0));
    run_both();
    pin("half_rw", 32'h010, 32'hAAAD1234);

    // Misaligned, bad size and out-of-range writes must leave memory alone.
    ops.delete();
    ops.push_back(mk_op(KNonseq, 1'b1, HSIZE_WORD, 32'h012, 32'hFFFFFFFF));
    ops.push_back(mk_op(KNonseq, 1'b1, 3'd3, 32'h010, 32'hFFFFFFFF));
    ops.push_back(mk_op(KNonseq, 1'b1, HSIZE_WORD, 32'h400, 32'hFFFFFFFF));
    ops.push_back(mk_op(KNonseq, 1'b1, HSIZE_HALF, 32'h011, 32'hFFFFFFFF));
    ops.push_back(mk_op(KNonseq, 1'b0, HSIZE_WORD, 32'h010, 32'h0));
    run_both();
    pin("err_nowrite", 32'h010, 32'hAAAD1234);

    // IDLE/BUSY with HSEL high and an unselected NONSEQ write have no effect.
    ops.delete();
    ops.push_back(mk_op(KIdle, 1'b1, HSIZE_WORD, 32'h010, 32'h0));
    ops.push_back(mk_op(KBusy, 1'b1, HSIZE_WORD, 32'h010, 32'h0));
    ops.push_back(mk_op(KUnsel, 1'b1, HSIZE_WORD, 32'h010, 32'h0));
    ops.push_back(mk_op(KNonseq, 1'b1, HSIZE_WORD, 32'h000, 32'h00000001));
    ops.push_back(mk_op(KNonseq, 1'b0, HSIZE_WORD, 32'h010, 32'h0));
    run_both();
    pin("idle_busy", 32'h010, 32'hAAAD1234);

    ops.delete();
    ops.push_back(mk_op(KNonseq, 1'b0, HSIZE_WORD, 32'h000, 32'h0));
    run_both();
    pin("wr_then_rd0", 32'h000, 32'h00000001);

    // Reset lands inside the write's data phase: the write is dropped.
    ops.delete();
    ops.push_back(mk_op(KNonseq, 1'b1, HSIZE_WORD, 32'h010, 32'h0BADF00D));
    ops.push_back(mk_op(KReset, 1'b0, HSIZE_BYTE, 32'h0, 32'h0));
    ops.push_back(mk_op(KNonseq, 1'b0, HSIZE_WORD, 32'h010, 32'h0));
    run_both();
    pin("rst_drop", 32'h010, 32'hAAAD1234);

    // Random traffic over a small window so reads often hit written bytes.
    ops.delete();
    for (int n = 0; n < 400; n++) begin
      r  = int'($urandom_range(0, 19));
      sz = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0 && sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 24) == 0) a = 32'h400 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 49) == 0) a = $urandom();
      o = mk_op(KNonseq, 1'($urandom_range(0, 1)), sz, a, $urandom());
      if (r < 13)      o.kind = (r % 2 == 0) ? KNonseq : KSeq;
      else if (r < 15) o.kind = KIdle;
      else if (r < 17) o.kind = KBusy;
      else if (r < 19) o.kind = KUnsel;
      else             o.kind = ($urandom_range(0, 3) == 0) ? KReset : KNonseq;
      ops.push_back(o);
    end
    run_both();

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
